// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan scheduler.
// Latency: none (package only).
// Backpressure: none (package only).
package adc_scan_pkg;

  localparam int ADC_W = 12;
  localparam int RES_W = 16;
  localparam int CH_W  = 4;
  localparam int CMD_W = 8;

  // low nibble of the ADC command word: 12-bit, MSB-first, unipolar
  localparam logic [3:0]       ADDR_LSB  = 4'b1000;
  // command word parked on the ADC while nothing is being scanned
  localparam logic [CMD_W-1:0] IDLE_ADDR = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_DROP,
    ST_ACC,
    ST_OUT,
    ST_FIN
  } scan_state_e;

  // index of the lowest set bit; 0 when the mask is empty
  function automatic logic [CH_W-1:0] lowest_ch(input logic [15:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_sched_if.sv
// Sampler command/response and averaged-result stream bundle.
// Latency: wires only.
// Backpressure: res_valid/res_ready handshake on the result stream.
interface adc_scan_sched_if;
  import adc_scan_pkg::*;

  logic              conv_en;
  logic [CMD_W-1:0]  conv_addr;
  logic              conv_done;
  logic [ADC_W-1:0]  conv_data;
  logic              res_valid;
  logic              res_ready;
  logic [CH_W-1:0]   res_ch;
  logic [RES_W-1:0]  res_data;

  // scheduler side
  modport master (
    output conv_en, conv_addr, res_valid, res_ch, res_data,
    input  conv_done, conv_data, res_ready
  );

  // sampler + result consumer side
  modport slave (
    input  conv_en, conv_addr, res_valid, res_ch, res_data,
    output conv_done, conv_data, res_ready
  );

endinterface

// File: rtl/adc_avg_acc.sv
// Sums 2**BIT_READ conversions and presents the shifted average.
// Latency: done/avg_nxt combinational with the final add; state updates next edge.
// Backpressure: none; caller gates add and holds the result elsewhere.
module adc_avg_acc
  import adc_scan_pkg::*;
#(
  parameter int BIT_READ = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [ADC_W-1:0]  data,
  output logic              done,
  output logic [RES_W-1:0]  avg_nxt
);

  localparam int AW = ADC_W + BIT_READ;
  localparam int CW = BIT_READ + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << BIT_READ) - 1);

  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;

  // wide enough that 2**BIT_READ full-scale samples cannot overflow
  assign sum     = acc_q + AW'(data);
  assign done    = add && !clr && (cnt_q == LAST);
  assign avg_nxt = RES_W'(sum[AW-1:BIT_READ]);

  // clear wins over add so an abort in the same cycle discards the sample
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // accumulator and sample counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Scans enabled ADC channels in ascending order, averaging 2**BIT_READ samples each.
// Latency: (DISCARD + 2**BIT_READ) conversions + 2 cycles per channel, plus handshake wait.
// Backpressure: res_ready low holds the result and keeps conv_en low. Option ADC_SCAN_CONT_EN: free-run while start held.
module adc_scan_sched
  import adc_scan_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int BIT_READ = 5,
  parameter int DISCARD  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_CH-1:0]   ch_mask,
  output logic              busy,
  output logic              scan_done,
  adc_scan_sched_if.master  bus
);

  localparam int DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

  scan_state_e       state_q, state_d;
  logic [N_CH-1:0]   mask_q, mask_d, rem_mask;
  logic [CH_W-1:0]   ch_q, ch_d, sel_ch;
  logic [DW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              drop_last;
  logic              busy_q, busy_d;
  logic              res_vld_q, res_vld_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              acc_clr, acc_add, acc_done;
  logic [RES_W-1:0]  avg_nxt;
`ifdef ADC_SCAN_CONT_EN
  logic [N_CH-1:0]   mask_lat_q;
`endif

  assign sel_ch    = lowest_ch(16'(mask_q));
  assign rem_mask  = mask_q & ~(N_CH'(1) << ch_q);
  assign drop_last = (drop_cnt_q == DW'(DISCARD - 1));
  assign acc_clr   = (state_q == ST_SEL) || abort;
  assign acc_add   = (state_q == ST_ACC) && bus.conv_done;

  adc_avg_acc #(.BIT_READ(BIT_READ)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .add     (acc_add),
    .data    (bus.conv_data),
    .done    (acc_done),
    .avg_nxt (avg_nxt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (ch_mask != '0) ? ST_SEL : ST_FIN;
      ST_SEL:  state_d = (DISCARD == 0) ? ST_ACC : ST_DROP;
      ST_DROP: if (bus.conv_done && drop_last) state_d = ST_ACC;
      ST_ACC:  if (acc_done) state_d = ST_OUT;
      ST_OUT:  if (bus.res_ready) state_d = (rem_mask != '0) ? ST_SEL : ST_FIN;
`ifdef ADC_SCAN_CONT_EN
      ST_FIN:  state_d = (start && mask_lat_q != '0) ? ST_SEL : ST_IDLE;
`else
      ST_FIN:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // FSM outputs: sampler enable/address and end-of-pass pulse
  always_comb begin
    bus.conv_en   = 1'b0;
    bus.conv_addr = IDLE_ADDR;
    scan_done     = 1'b0;
    case (state_q)
      ST_SEL: begin
        bus.conv_en   = 1'b1;
        bus.conv_addr = {sel_ch, ADDR_LSB};
      end
      ST_DROP, ST_ACC: begin
        bus.conv_en   = 1'b1;
        bus.conv_addr = {ch_q, ADDR_LSB};
      end
      ST_OUT:  bus.conv_addr = {ch_q, ADDR_LSB};
      ST_FIN:  scan_done = !abort;
      default: ;
    endcase
  end

  // datapath next state: mask walk, drop counter, result stream register
  always_comb begin
    mask_d     = mask_q;
    ch_d       = ch_q;
    drop_cnt_d = drop_cnt_q;
    res_vld_d  = res_vld_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: if (start && !abort) mask_d = ch_mask;
      ST_SEL: begin
        ch_d       = sel_ch;
        drop_cnt_d = '0;
      end
      ST_DROP: if (bus.conv_done) drop_cnt_d = drop_cnt_q + 1'b1;
      ST_ACC: if (acc_done) begin
        res_vld_d  = 1'b1;
        res_ch_d   = ch_q;
        res_data_d = avg_nxt;
      end
      ST_OUT: if (bus.res_ready) begin
        res_vld_d = 1'b0;
        mask_d    = rem_mask;
      end
`ifdef ADC_SCAN_CONT_EN
      ST_FIN: if (start) mask_d = mask_lat_q;
`endif
      default: ;
    endcase
    if (abort) res_vld_d = 1'b0;
  end

  // busy stays low through an empty-mask pass (IDLE -> FIN -> IDLE)
  assign busy_d = (state_d != ST_IDLE) && !(state_q == ST_IDLE && state_d == ST_FIN);

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      ch_q       <= '0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
    end else begin
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
      res_vld_q  <= res_vld_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
    end
  end

`ifdef ADC_SCAN_CONT_EN
  // mask captured at start, reloaded on every free-run pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       mask_lat_q <= '0;
    else if (state_q == ST_IDLE && start && !abort)   mask_lat_q <= ch_mask;
  end
`endif

  assign busy          = busy_q;
  assign bus.res_valid = res_vld_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
module tb_adc_scan_sched;
  import adc_scan_pkg::*;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [N_CH-1:0] ch_mask = '0;
  logic            busy, scan_done;

  adc_scan_sched_if bus();

  adc_scan_sched #(.N_CH(N_CH), .BIT_READ(5), .DISCARD(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .ch_mask   (ch_mask),
    .busy      (busy),
    .scan_done (scan_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_results = 0;
  int   pulses = 0;
  bit   ramp = 1'b0;
  bit   inject = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [3:0] m);
    ch_mask = m;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (scan_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, scan_done, 1);
  endtask

  // sampler model: one conv_done every 3 enabled cycles; first one after
  // an address change returns the previous channel (4095 marker)
  initial begin
    int phase, idx;
    phase = 0;
    idx   = 0;
    bus.conv_done = 1'b0;
    bus.conv_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.conv_done = 1'b0;
      if (!rst_n || (!bus.conv_en && !inject)) begin
        phase = 0;
        idx   = 0;
      end else begin
        phase++;
        if (phase == 3) begin
          phase = 0;
          bus.conv_done = 1'b1;
          if (inject) begin
            bus.conv_data = 12'hFFF;
          end else begin
            if (idx == 0)  bus.conv_data = 12'hFFF;
            else if (ramp) bus.conv_data = 12'(idx - 1);
            else           bus.conv_data = 12'd100;
            idx++;
            pulses++;
          end
        end
      end
    end
  end

  // result monitor: pop the scoreboard on every accepted result
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.res_valid && bus.res_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=0 expected=1 res_ch=%0d", bus.res_ch);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("res_ch", 32'(bus.res_ch), 32'(mon_e.ch));
          chk("res_data", 32'(bus.res_data), 32'(mon_e.data));
        end
        n_results++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, n, unstable;
    logic [15:0] held;
    bus.res_ready = 1'b1;
    step(3);

    chk("rst_conv_addr", bus.conv_addr, 32'h38);
    chk("rst_conv_en", bus.conv_en, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_ch", bus.res_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scan_done", scan_done, 0);
    rst_n = 1'b1;
    step(2);

    // start and abort together: abort wins
    ch_mask = 4'b0001; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_en", bus.conv_en, 0);
    step(2);

    // two channels, constant data
    ramp = 1'b0;
    sb.push_back('{4'd0, 16'd100});
    sb.push_back('{4'd2, 16'd100});
    p0 = pulses; r0 = n_results;
    do_start(4'b0101);
    chk("t1_busy", busy, 1);
    chk("t1_conv_en", bus.conv_en, 1);
    chk("t1_first_addr", bus.conv_addr, 32'h08);
    wait_done("t1_done", 3000);
    chk("t1_pulses", pulses - p0, 66);
    chk("t1_results", n_results - r0, 2);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_idle_addr", bus.conv_addr, 32'h38);
    chk("t1_done_pulse", scan_done, 0);

    // ramp on ch1, stale sample excluded; start while busy ignored
    ramp = 1'b1;
    sb.push_back('{4'd1, 16'd15});
    p0 = pulses;
    do_start(4'b0010);
    step(40);
    do_start(4'b1111);
    chk("t2_busy_ignore", busy, 1);
    chk("t2_addr_ignore", bus.conv_addr, 32'h18);
    wait_done("t2_done", 2000);
    chk("t2_pulses", pulses - p0, 33);
    ramp = 1'b0;
    step(2);

    // consumer stall in OUT with stray conv_done pulses
    sb.push_back('{4'd0, 16'd100});
    bus.res_ready = 1'b0;
    do_start(4'b0001);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 500) begin step(); n++; end
    chk("t3_valid", bus.res_valid, 1);
    held = bus.res_data;
    unstable = 0;
    inject = 1'b1;
    repeat (50) begin
      step();
      if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.res_ch !== 4'd0 || bus.conv_en !== 1'b0)
        unstable++;
    end
    inject = 1'b0;
    chk("t3_stall_stable", unstable, 0);
    chk("t3_held_data", held, 100);
    bus.res_ready = 1'b1;
    wait_done("t3_done", 100);
    step(2);

    // empty mask
    r0 = n_results;
    do_start(4'b0000);
    chk("t4_scan_done", scan_done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", bus.res_valid, 0);
    step();
    chk("t4_done_drop", scan_done, 0);
    chk("t4_busy_after", busy, 0);
    chk("t4_no_results", n_results - r0, 0);

    // abort mid-accumulation on ch2, then restart from ch0
    sb.push_back('{4'd0, 16'd100});
    do_start(4'b0101);
    n = 0;
    while (bus.conv_addr !== 8'h28 && n < 1000) begin step(); n++; end
    chk("t5_reach_ch2", bus.conv_addr, 32'h28);
    step(30);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_conv_en", bus.conv_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_valid", bus.res_valid, 0);
    chk("t5_addr", bus.conv_addr, 32'h38);
    chk("t5_no_done", scan_done, 0);
    step(40);
    chk("t5_still_idle", bus.res_valid, 0);
    chk("t5_sb_drained", sb.size(), 0);
    sb.push_back('{4'd0, 16'd100});
    sb.push_back('{4'd2, 16'd100});
    do_start(4'b0101);
    chk("t5_restart_addr", bus.conv_addr, 32'h08);
    wait_done("t5_done", 3000);
    step(2);

    // reset in the middle of a scan
    r0 = n_results;
    do_start(4'b0001);
    step(20);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_en", bus.conv_en, 0);
    chk("t6_rst_addr", bus.conv_addr, 32'h38);
    step(2);
    rst_n = 1'b1;
    step(120);
    chk("t6_no_result", n_results - r0, 0);

`ifdef ADC_SCAN_CONT_EN
    // free-run: two passes while start is held
    sb.push_back('{4'd3, 16'd100});
    sb.push_back('{4'd3, 16'd100});
    ch_mask = 4'b1000;
    start = 1'b1;
    step();
    chk("t7_busy", busy, 1);
    wait_done("t7_pass1", 2000);
    step();
    chk("t7_reloop_en", bus.conv_en, 1);
    wait_done("t7_pass2", 2000);
    start = 1'b0;
    step();
    chk("t7_stopped", busy, 0);
    step(150);
    chk("t7_no_more", bus.res_valid, 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
